// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder
// Watches a time-multiplexed, active-low 7-segment bus (anodes plus abcdefg
// cathodes) and recovers the hex value shown on each digit. Once every digit
// has been captured, the recovered digits are published as one frame. A
// stability counter raises 'locked' after STABLE_FRAMES identical frames in a row.
//
// Optional feature macro: SSEG_DP_EN
//   When it is defined, the module adds a decimal-point input 'dp' (active-low)
//   and a 'dp_mask' output. dp takes part in the change detection, is captured
//   per digit and is published with the frame.
module sseg_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int SETTLE_CYCLES = 4,
   parameter int STABLE_FRAMES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_DIGITS-1:0]   an,
   input  logic [6:0]              sseg,
`ifdef SSEG_DP_EN
   input  logic                    dp,
   output logic [NUM_DIGITS-1:0]   dp_mask,
`endif
   output logic [4*NUM_DIGITS-1:0] hex_out,
   output logic [NUM_DIGITS-1:0]   dash_mask,
   output logic [NUM_DIGITS-1:0]   err_mask,
   output logic                    frame_valid,
   output logic                    locked
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam int SW = $clog2(STABLE_FRAMES + 1);
`ifdef SSEG_DP_EN
   localparam int PW = 8;
`else
   localparam int PW = 7;
`endif

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLE   = 2'd1,
      CAPTURED = 2'd2
   } state_t;

   // Pattern decode: returns {err, dash, nibble}.
   function automatic logic [5:0] decode_seg(input logic [6:0] seg);
      logic [5:0] r;
      case (seg)
         7'b0000001: r = {2'b00, 4'h0};
         7'b1001111: r = {2'b00, 4'h1};
         7'b0010010: r = {2'b00, 4'h2};
         7'b0000110: r = {2'b00, 4'h3};
         7'b1001100: r = {2'b00, 4'h4};
         7'b0100100: r = {2'b00, 4'h5};
         7'b0100000: r = {2'b00, 4'h6};
         7'b0001111: r = {2'b00, 4'h7};
         7'b0000000: r = {2'b00, 4'h8};
         7'b0000100: r = {2'b00, 4'h9};
         7'b0001000: r = {2'b00, 4'hA};
         7'b1100000: r = {2'b00, 4'hB};
         7'b0110001: r = {2'b00, 4'hC};
         7'b1000010: r = {2'b00, 4'hD};
         7'b0110000: r = {2'b00, 4'hE};
         7'b0111000: r = {2'b00, 4'hF};
         7'b1111110: r = {2'b01, 4'h0};
         default:    r = {2'b10, 4'h0};
      endcase
      return r;
   endfunction

   // Position of the (single) low anode bit.
   function automatic logic [IW-1:0] digit_index(input logic [NUM_DIGITS-1:0] an_v);
      logic [IW-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an_v[i]) idx = IW'(i);
      end
      return idx;
   endfunction

   // Synchronizer, previous-cycle copies
   logic [PW-1:0]         pat_in;
   logic [NUM_DIGITS-1:0] an_m_q,  an_m_d;
   logic [NUM_DIGITS-1:0] an_s_q,  an_s_d;
   logic [NUM_DIGITS-1:0] an_p_q,  an_p_d;
   logic [PW-1:0]         pat_m_q, pat_m_d;
   logic [PW-1:0]         pat_s_q, pat_s_d;
   logic [PW-1:0]         pat_p_q, pat_p_d;

   // Capture FSM and shadow frame
   state_t                  state_q,     state_d;
   logic [CW-1:0]           cnt_q,       cnt_d;
   logic [NUM_DIGITS-1:0]   seen_q,      seen_d;
   logic [4*NUM_DIGITS-1:0] hex_sh_q,    hex_sh_d;
   logic [NUM_DIGITS-1:0]   dash_sh_q,   dash_sh_d;
   logic [NUM_DIGITS-1:0]   err_sh_q,    err_sh_d;

   // Published frame and lock tracking
   logic [4*NUM_DIGITS-1:0] hex_out_q,   hex_out_d;
   logic [NUM_DIGITS-1:0]   dash_out_q,  dash_out_d;
   logic [NUM_DIGITS-1:0]   err_out_q,   err_out_d;
   logic                    fv_q,        fv_d;
   logic [SW-1:0]           stable_q,    stable_d;
   logic                    locked_q,    locked_d;
   logic                    has_frame_q, has_frame_d;

`ifdef SSEG_DP_EN
   logic [NUM_DIGITS-1:0]   dp_sh_q,     dp_sh_d;
   logic [NUM_DIGITS-1:0]   dp_out_q,    dp_out_d;
`endif

   logic                    an_ok;
   logic                    bus_chg;
   logic [IW-1:0]           idx;
   logic [5:0]              dec;
   logic                    do_sample;
   logic                    same_frame;

`ifdef SSEG_DP_EN
   assign pat_in = {dp, sseg};
`else
   assign pat_in = sseg;
`endif

   // Two-flop synchronizer plus one extra stage for change detection.
   always_comb begin
      an_m_d  = an;
      an_s_d  = an_m_q;
      an_p_d  = an_s_q;
      pat_m_d = pat_in;
      pat_s_d = pat_m_q;
      pat_p_d = pat_s_q;
   end

   assign an_ok   = $onehot(~an_s_q);
   assign bus_chg = (an_s_q != an_p_q) || (pat_s_q != pat_p_q);
   assign idx     = digit_index(an_s_q);
   assign dec     = decode_seg(pat_s_q[6:0]);

   // Next-state for the dwell FSM, shadow capture and frame publication.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      seen_d      = seen_q;
      hex_sh_d    = hex_sh_q;
      dash_sh_d   = dash_sh_q;
      err_sh_d    = err_sh_q;
      hex_out_d   = hex_out_q;
      dash_out_d  = dash_out_q;
      err_out_d   = err_out_q;
      fv_d        = 1'b0;
      stable_d    = stable_q;
      locked_d    = locked_q;
      has_frame_d = has_frame_q;
      do_sample   = 1'b0;
      same_frame  = 1'b0;
`ifdef SSEG_DP_EN
      dp_sh_d     = dp_sh_q;
      dp_out_d    = dp_out_q;
`endif

      // Dwell tracking: the count is the number of consecutive synchronized
      // cycles the bus has held its current value with a valid anode.
      case (state_q)
         IDLE: begin
            if (an_ok) begin
               state_d = SETTLE;
               cnt_d   = CW'(1);
            end
         end
         SETTLE: begin
            if (!an_ok) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (bus_chg) begin
               cnt_d   = CW'(1);
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         CAPTURED: begin
            if (!an_ok) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (bus_chg) begin
               state_d = SETTLE;
               cnt_d   = CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // One sample per dwell: taking it parks the FSM in CAPTURED until the
      // bus moves again.
      if (state_d == SETTLE && cnt_d >= CW'(SETTLE_CYCLES)) begin
         do_sample = 1'b1;
         state_d   = CAPTURED;
         cnt_d     = '0;
      end

      if (do_sample) begin
         hex_sh_d[{idx, 2'b00} +: 4] = dec[3:0];
         dash_sh_d[idx]              = dec[4];
         err_sh_d[idx]               = dec[5];
`ifdef SSEG_DP_EN
         dp_sh_d[idx]                = ~pat_s_q[7];
`endif
         seen_d[idx]                 = 1'b1;
      end

      // Frame complete: publish the shadow and update the stability count
      // against the previously published frame.
      if (do_sample && (&seen_d)) begin
         same_frame = has_frame_q
                      && (hex_sh_d  == hex_out_q)
                      && (dash_sh_d == dash_out_q)
`ifdef SSEG_DP_EN
                      && (dp_sh_d   == dp_out_q)
`endif
                      && (err_sh_d  == err_out_q);
         hex_out_d   = hex_sh_d;
         dash_out_d  = dash_sh_d;
         err_out_d   = err_sh_d;
`ifdef SSEG_DP_EN
         dp_out_d    = dp_sh_d;
`endif
         fv_d        = 1'b1;
         seen_d      = '0;
         has_frame_d = 1'b1;
         if (same_frame) begin
            if (stable_q < SW'(STABLE_FRAMES)) stable_d = stable_q + SW'(1);
         end else begin
            stable_d = SW'(1);
         end
         locked_d = (stable_d >= SW'(STABLE_FRAMES));
      end
   end

   // State registers; reset returns the bus copies to the idle (all-high) level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_m_q      <= '1;
         an_s_q      <= '1;
         an_p_q      <= '1;
         pat_m_q     <= '1;
         pat_s_q     <= '1;
         pat_p_q     <= '1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         seen_q      <= '0;
         hex_sh_q    <= '0;
         dash_sh_q   <= '0;
         err_sh_q    <= '0;
         hex_out_q   <= '0;
         dash_out_q  <= '0;
         err_out_q   <= '0;
         fv_q        <= 1'b0;
         stable_q    <= '0;
         locked_q    <= 1'b0;
         has_frame_q <= 1'b0;
`ifdef SSEG_DP_EN
         dp_sh_q     <= '0;
         dp_out_q    <= '0;
`endif
      end else begin
         an_m_q      <= an_m_d;
         an_s_q      <= an_s_d;
         an_p_q      <= an_p_d;
         pat_m_q     <= pat_m_d;
         pat_s_q     <= pat_s_d;
         pat_p_q     <= pat_p_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         seen_q      <= seen_d;
         hex_sh_q    <= hex_sh_d;
         dash_sh_q   <= dash_sh_d;
         err_sh_q    <= err_sh_d;
         hex_out_q   <= hex_out_d;
         dash_out_q  <= dash_out_d;
         err_out_q   <= err_out_d;
         fv_q        <= fv_d;
         stable_q    <= stable_d;
         locked_q    <= locked_d;
         has_frame_q <= has_frame_d;
`ifdef SSEG_DP_EN
         dp_sh_q     <= dp_sh_d;
         dp_out_q    <= dp_out_d;
`endif
      end
   end

   assign hex_out     = hex_out_q;
   assign dash_mask   = dash_out_q;
   assign err_mask    = err_out_q;
   assign frame_valid = fv_q;
   assign locked      = locked_q;
`ifdef SSEG_DP_EN
   assign dp_mask     = dp_out_q;
`endif

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Testbench for sseg_scan_decoder: directed scans from the test plan followed
// by randomized dwells, checked by a frame scoreboard fed from a dwell-level
// reference model.
module tb_sseg_scan_decoder;

   localparam int ND = 4;
   localparam int SC = 4;
   localparam int SF = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  an = 4'hF;
   logic [6:0]  sseg = 7'h7F;
   logic [15:0] hex_out;
   logic [3:0]  dash_mask;
   logic [3:0]  err_mask;
   logic        frame_valid;
   logic        locked;

   always #5 clk = ~clk;

   sseg_scan_decoder #(
      .NUM_DIGITS   (ND),
      .SETTLE_CYCLES(SC),
      .STABLE_FRAMES(SF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .an         (an),
      .sseg       (sseg),
      .hex_out    (hex_out),
      .dash_mask  (dash_mask),
      .err_mask   (err_mask),
      .frame_valid(frame_valid),
      .locked     (locked)
   );

   typedef struct packed {
      logic [15:0] hex;
      logic [3:0]  dash;
      logic [3:0]  err;
      logic        lck;
   } frame_t;

   frame_t exp_q[$];
   int     vectors     = 0;
   int     miscompares = 0;
   int     frames_seen = 0;
   logic   fv_prev     = 1'b0;

   logic [6:0] seg_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000 };

   // Reference model state: per-digit shadow, last published frame, run tracker
   logic [15:0] m_hex, last_hex;
   logic [3:0]  m_dash, m_err, m_seen, last_dash, last_err;
   int          m_stable;
   bit          m_have;
   logic [10:0] run_key;
   int          run_len;
   bit          run_act, run_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] model_decode(input logic [6:0] s);
      if (s == 7'b1111110) return 6'b010000;
      for (int i = 0; i < 16; i++) begin
         if (seg_tab[i] == s) return {2'b00, 4'(i)};
      end
      return 6'b100000;
   endfunction

   task automatic model_clear();
      m_hex = '0; m_dash = '0; m_err = '0; m_seen = '0;
      last_hex = '0; last_dash = '0; last_err = '0;
      m_stable = 0; m_have = 0;
      run_key = '1; run_len = 0; run_act = 0; run_done = 0;
   endtask

   task automatic model_capture(input int d, input logic [6:0] s);
      logic [5:0] r;
      frame_t     f;
      r = model_decode(s);
      m_hex[d*4 +: 4] = r[3:0];
      m_dash[d]       = r[4];
      m_err[d]        = r[5];
      m_seen[d]       = 1'b1;
      if (m_seen == 4'hF) begin
         if (m_have && m_hex == last_hex && m_dash == last_dash && m_err == last_err)
            m_stable = (m_stable < SF) ? m_stable + 1 : SF;
         else
            m_stable = 1;
         f.hex  = m_hex;
         f.dash = m_dash;
         f.err  = m_err;
         f.lck  = (m_stable >= SF);
         exp_q.push_back(f);
         last_hex = m_hex; last_dash = m_dash; last_err = m_err;
         m_have = 1;
         m_seen = '0;
      end
   endtask

   // Hold one bus value for len clocks. A run of identical values with a single
   // low anode that lasts at least SC clocks yields exactly one capture.
   task automatic apply_dwell(input logic [3:0] an_v, input logic [6:0] seg_v, input int len);
      bit          valid;
      logic [10:0] key;
      int          d;
      valid = ($countones(~an_v) == 1);
      key   = {an_v, seg_v};
      if (valid && run_act && key == run_key) begin
         run_len += len;
      end else begin
         run_key  = key;
         run_len  = len;
         run_act  = valid;
         run_done = 0;
      end
      if (run_act && !run_done && run_len >= SC) begin
         run_done = 1;
         d = 0;
         for (int i = 0; i < ND; i++) if (!an_v[i]) d = i;
         model_capture(d, seg_v);
      end
      an   = an_v;
      sseg = seg_v;
      repeat (len) @(negedge clk);
   endtask

   task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3, input int len);
      apply_dwell(4'b1110, p0, len);
      apply_dwell(4'b1101, p1, len);
      apply_dwell(4'b1011, p2, len);
      apply_dwell(4'b0111, p3, len);
   endtask

   // Scoreboard monitor: every frame_valid pulse pops one expected frame.
   always begin
      frame_t e;
      @(posedge clk);
      #1;
      if (frame_valid) begin
         frames_seen++;
         chk("fv_single_cycle", 32'(fv_prev), 32'd0);
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: actual hex=%h required no frame at %0t", hex_out, $time);
         end else begin
            e = exp_q.pop_front();
            chk("frame_hex",    32'(hex_out),   32'(e.hex));
            chk("frame_dash",   32'(dash_mask), 32'(e.dash));
            chk("frame_err",    32'(err_mask),  32'(e.err));
            chk("frame_locked", 32'(locked),    32'(e.lck));
         end
      end
      fv_prev = frame_valid;
   end

   initial begin
      int          fc;
      int          r;
      logic [3:0]  an_v;
      logic [6:0]  seg_v;
      logic [3:0]  bad_an [4] = '{4'b1111, 4'b1100, 4'b0000, 4'b1010};

      model_clear();
      #1 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset_hex",    32'(hex_out),     32'd0);
      chk("reset_dash",   32'(dash_mask),   32'd0);
      chk("reset_err",    32'(err_mask),    32'd0);
      chk("reset_fv",     32'(frame_valid), 32'd0);
      chk("reset_locked", 32'(locked),      32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Basic scan, then an identical frame to lock
      fc = frames_seen;
      scan(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4], 16);
      chk("scan1_hex",    32'(hex_out), 32'h4321);
      chk("scan1_locked", 32'(locked),  32'd0);
      chk("scan1_frames", 32'(frames_seen), 32'(fc + 1));
      scan(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4], 16);
      chk("scan2_locked", 32'(locked),  32'd1);

      // Letters and dash
      scan(seg_tab[11], seg_tab[13], 7'b1111110, seg_tab[12], 16);
      chk("bdc_hex",  32'(hex_out),   32'hC0DB);
      chk("bdc_dash", 32'(dash_mask), 32'b0100);
      chk("bdc_err",  32'(err_mask),  32'b0000);

      // Unrecognized pattern on digit1
      scan(seg_tab[1], 7'b1010101, seg_tab[3], seg_tab[4], 16);
      chk("err_mask",   32'(err_mask),     32'b0010);
      chk("err_nibble", 32'(hex_out[7:4]), 32'd0);

      // Short dwell on digit2 is ignored
      fc = frames_seen;
      apply_dwell(4'b1110, seg_tab[5], 16);
      apply_dwell(4'b1101, seg_tab[6], 16);
      apply_dwell(4'b1011, seg_tab[7], 3);
      apply_dwell(4'b0111, seg_tab[8], 16);
      chk("short_dwell_no_frame", 32'(frames_seen), 32'(fc));
      apply_dwell(4'b1011, seg_tab[7], 16);
      chk("long_dwell_frame", 32'(frames_seen), 32'(fc + 1));
      chk("long_dwell_hex",   32'(hex_out),     32'h8765);

      // Lose lock on a changed digit, regain it
      scan(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4], 16);
      scan(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4], 16);
      chk("relock_pre", 32'(locked), 32'd1);
      fc = frames_seen;
      scan(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[5], 16);
      chk("change_hex",    32'(hex_out),     32'h5321);
      chk("change_locked", 32'(locked),      32'd0);
      chk("change_frames", 32'(frames_seen), 32'(fc + 1));
      scan(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[5], 16);
      scan(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[5], 16);
      chk("change_relock", 32'(locked), 32'd1);

      // Reset after two digits captured
      apply_dwell(4'b1110, seg_tab[9], 16);
      apply_dwell(4'b1101, seg_tab[10], 16);
      apply_dwell(4'b1111, 7'h7F, 8);
      chk("pre_reset_pending", 32'(exp_q.size()), 32'd0);
      reset = 1'b1;
      #1;
      chk("mid_reset_hex",    32'(hex_out),   32'd0);
      chk("mid_reset_dash",   32'(dash_mask), 32'd0);
      chk("mid_reset_err",    32'(err_mask),  32'd0);
      chk("mid_reset_locked", 32'(locked),    32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_clear();
      fc = frames_seen;
      apply_dwell(4'b1011, seg_tab[11], 16);
      apply_dwell(4'b0111, seg_tab[12], 16);
      chk("post_reset_partial", 32'(frames_seen), 32'(fc));
      apply_dwell(4'b1110, seg_tab[9], 16);
      apply_dwell(4'b1101, seg_tab[10], 16);
      chk("post_reset_full", 32'(frames_seen), 32'(fc + 1));
      chk("post_reset_hex",  32'(hex_out),     32'hCBA9);

      // Randomized dwells
      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 10) an_v = bad_an[$urandom_range(0, 3)];
         else        an_v = 4'(~(4'b0001 << $urandom_range(0, 3)));
         r = int'($urandom_range(0, 99));
         if (r < 75)      seg_v = seg_tab[$urandom_range(0, 15)];
         else if (r < 85) seg_v = 7'b1111110;
         else             seg_v = 7'($urandom);
         apply_dwell(an_v, seg_v, int'($urandom_range(1, 8)));
      end

      apply_dwell(4'b1111, 7'h7F, 12);
      chk("pending_frames", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sseg_scan_decoder.md
# sseg_scan_decoder

- Receive-side counterpart of the hex-to-7-segment encoder.
- Watches a time-multiplexed, active-low 7-segment bus (anodes plus abcdefg cathodes) and recovers the 4-bit value shown on each digit.
- Publishes the recovered digits as a full frame once every digit has been captured.
- Used as an on-chip monitor and self-check of the display driver path, and as a bench scoreboard front-end.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (one anode each)
- SETTLE_CYCLES, 4, consecutive cycles an/sseg must be unchanged before a digit is sampled
- STABLE_FRAMES, 2, consecutive identical frames required to assert locked
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- an  input  NUM_DIGITS  anode enables, active-low; digit i selected when only an[i]=0
- sseg  input  7  cathodes {a,b,c,d,e,f,g}, active-low
- hex_out  output  4*NUM_DIGITS  decoded digits; digit i at [4i+3:4i]
- dash_mask  output  NUM_DIGITS  bit i set: digit i showed '-' (1111110)
- err_mask  output  NUM_DIGITS  bit i set: digit i showed an unrecognized pattern
- frame_valid  output  1  one-cycle pulse when outputs update
- locked  output  1  STABLE_FRAMES identical frames seen in a row

## Operation
- an and sseg pass through a 2-flop synchronizer; all logic below uses the synchronized copies.
- Anode valid = exactly one bit low. All-high or multiple-low counts as invalid: return to IDLE and clear the settle counter.
- State machine:
  - IDLE: valid anode -> SETTLE with count=1.
  - SETTLE: if an or sseg differs from the previous cycle, restart count=1 (or go to IDLE if the anode is invalid). When count reaches SETTLE_CYCLES, sample -> CAPTURED.
  - CAPTURED: hold until an or sseg changes, then evaluate as in IDLE. Result: exactly one sample per dwell.
- Decode table (sseg -> nibble):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F
  - 1111110 -> nibble 0, dash bit set
  - Anything else, including blank 1111111 -> nibble 0, err bit set
- Sample writes the shadow nibble, dash and err bits for the selected digit and sets seen[i]. A repeat sample of the same digit before frame end overwrites the shadow.
- When seen becomes all ones:
  - Copy shadow to hex_out, dash_mask and err_mask; pulse frame_valid; clear seen.
  - Compare against the previous published frame:
    - Identical: stable count increments, saturating at STABLE_FRAMES.
    - Different: stable count = 1.
  - locked = (stable count >= STABLE_FRAMES). The first frame after reset sets count=1.

## Timing
- Reset values: hex_out=0, dash_mask=0, err_mask=0, frame_valid=0, locked=0. Also state=IDLE, seen=0, counters=0, shadow=0.
- Minimum dwell for capture = SETTLE_CYCLES clocks of stable synchronized input. A shorter dwell is ignored, and that digit stays unseen.
- Latency:
  - Input pin to the synchronized copy: 2 cycles.
  - The final digit's sample to frame_valid, and to the updated hex_out/masks/locked: 1 cycle. All of these change in the same cycle.
- frame_valid is never high for 2 consecutive cycles.
- Reset asserted mid-frame discards all partial captures. The first frame after release needs every digit captured again.

## Configuration
- SSEG_DP_EN defined:
  - Adds input dp (1 bit, active-low decimal point) and output dp_mask (NUM_DIGITS, reset 0).
  - dp is part of the settle/change comparison and is captured per digit.
  - dp_mask is published with the frame and is included in the identical-frame comparison.
- SSEG_DP_EN undefined:
  - No dp or dp_mask ports exist.
  - Behaviour is exactly as described above.

## Test plan
- Scan an=1110,1101,1011,0111 with sseg 1001111, 0010010, 0000110, 1001100, 16-cycle dwell:
  - First frame: hex_out=16'h4321, one frame_valid pulse, locked=0.
  - Second identical frame: locked=1.
- Digits B, D, '-', C (digit0..3):
  - hex_out=16'hC0DB, dash_mask=4'b0100, err_mask=4'b0000.
- Digit1 pattern 1010101:
  - err_mask=4'b0010, hex_out[7:4]=0.
- Digit2 dwell 3 cycles with SETTLE_CYCLES=4:
  - No frame_valid until a later dwell on digit2 lasts at least 4 cycles.
- While locked, change digit3 from 4 to 5:
  - That frame: hex_out=16'h5321, frame_valid pulses, locked=0.
  - Two more identical frames later: locked=1.
- Assert reset after 2 of 4 digits are captured:
  - All outputs 0 immediately.
  - After release, a full 4-digit scan is needed before frame_valid.
